i2c_master_seq: RTL

Parametrised I2C master sequencer: executes START, repeated START, STOP, byte WRITE and byte READ commands as a phase-timed state machine driving open-drain SCL/SDA enables. It generalises the single start-phase step into a full command engine with configurable counter width, a valid/ready command port, a response port, error reporting and optional clock stretching. It sits between the I2C transaction controller and the pad-level open-drain buffers.

---
 rtl/i2c_master_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_seq.sv
// rtl/i2c_master_seq.sv - I2C master command sequencer driving open-drain SCL/SDA enables
// Optional clock stretching when I2C_CLOCK_STRETCH_EN is defined.
module i2c_master_seq #(
   parameter int CTR_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CTR_WIDTH-1:0] dbl_clock_divisor,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd,
   input  logic [7:0]           cmd_data,
   input  logic                 cmd_nack,
   output logic                 rsp_valid,
   output logic [7:0]           rsp_data,
   output logic                 rsp_nack,
   output logic                 rsp_err,
   output logic                 scl_out,
   output logic                 sda_out,
   input  logic                 scl_in,
   input  logic                 sda_in,
   output logic                 bus_owned
);

   localparam logic [2:0] CMD_START   = 3'd0;
   localparam logic [2:0] CMD_RESTART = 3'd1;
   localparam logic [2:0] CMD_STOP    = 3'd2;
   localparam logic [2:0] CMD_WRITE   = 3'd3;
   localparam logic [2:0] CMD_READ    = 3'd4;

   typedef enum logic [3:0] {
      K_IDLE,
      K_RSTART1,
      K_RSTART2,
      K_START1,
      K_START2,
      K_BIT_LOW,
      K_BIT_HIGH,
      K_HOLD,
      K_STOP1,
      K_STOP2,
      K_STOP3
   } state_t;

   state_t               state;
   logic [CTR_WIDTH-1:0] ctr;
   logic [CTR_WIDTH-1:0] div;
   logic [3:0]           bit_cnt;
   logic [8:0]           tx;
   logic [7:0]           rx;
   logic                 ack_bit;
   logic                 legal;
   logic                 stretch;
   logic [8:0]           tx_init;

`ifdef I2C_CLOCK_STRETCH_EN
   // A slave holding SCL low while we release it freezes the phase.
   assign stretch = scl_out && !scl_in;
`else
   logic unused_scl_in;
   assign unused_scl_in = scl_in;
   assign stretch       = 1'b0;
`endif

   // Bits 1-8 then bit 9; the side not driving a bit leaves SDA released.
   assign tx_init = (cmd == CMD_WRITE) ? {cmd_data, 1'b1} : {8'hFF, cmd_nack};

   always_comb begin
      legal = 1'b0;
      case (cmd)
         CMD_START:                                   legal = !bus_owned;
         CMD_RESTART, CMD_STOP, CMD_WRITE, CMD_READ:  legal = bus_owned;
         default:                                     legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= K_IDLE;
         ctr       <= '0;
         div       <= '0;
         bit_cnt   <= '0;
         tx        <= '0;
         rx        <= '0;
         ack_bit   <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_nack  <= 1'b0;
         rsp_err   <= 1'b0;
         scl_out   <= 1'b1;
         sda_out   <= 1'b1;
         bus_owned <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         if (state == K_IDLE) begin
            if (cmd_valid && cmd_ready) begin
               ctr <= '0;
               div <= dbl_clock_divisor;
               if (!legal) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
                  rsp_nack  <= 1'b0;
               end else begin
                  cmd_ready <= 1'b0;
                  case (cmd)
                     CMD_START: begin
                        state   <= K_START1;
                        scl_out <= 1'b1;
                        sda_out <= 1'b0;
                     end
                     CMD_RESTART: begin
                        state   <= K_RSTART1;
                        scl_out <= 1'b0;
                        sda_out <= 1'b1;
                     end
                     CMD_STOP: begin
                        state   <= K_STOP1;
                        scl_out <= 1'b0;
                        sda_out <= 1'b0;
                     end
                     default: begin
                        state   <= K_BIT_LOW;
                        scl_out <= 1'b0;
                        sda_out <= tx_init[8];
                        tx      <= {tx_init[7:0], 1'b0};
                        bit_cnt <= '0;
                        rx      <= '0;
                     end
                  endcase
               end
            end
         end else if (stretch) begin
            ctr <= '0;
         end else if (ctr != div) begin
            ctr <= ctr + 1'b1;
         end else begin
            ctr <= '0;
            case (state)
               K_RSTART1: begin
                  state   <= K_RSTART2;
                  scl_out <= 1'b1;
                  sda_out <= 1'b1;
               end
               K_RSTART2: begin
                  state   <= K_START1;
                  scl_out <= 1'b1;
                  sda_out <= 1'b0;
               end
               K_START1: begin
                  state   <= K_START2;
                  scl_out <= 1'b0;
                  sda_out <= 1'b0;
               end
               K_START2: begin
                  state     <= K_IDLE;
                  bus_owned <= 1'b1;
                  cmd_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= '0;
                  rsp_nack  <= 1'b0;
               end
               K_BIT_LOW: begin
                  state   <= K_BIT_HIGH;
                  scl_out <= 1'b1;
               end
               K_BIT_HIGH: begin
                  scl_out <= 1'b0;
                  if (bit_cnt == 4'd8) begin
                     state   <= K_HOLD;
                     ack_bit <= sda_in;
                  end else begin
                     state   <= K_BIT_LOW;
                     rx      <= {rx[6:0], sda_in};
                     bit_cnt <= bit_cnt + 4'd1;
                     sda_out <= tx[8];
                     tx      <= {tx[7:0], 1'b0};
                  end
               end
               K_HOLD: begin
                  state     <= K_IDLE;
                  cmd_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= rx;
                  rsp_nack  <= ack_bit;
               end
               K_STOP1: begin
                  state   <= K_STOP2;
                  scl_out <= 1'b1;
                  sda_out <= 1'b0;
               end
               K_STOP2: begin
                  state   <= K_STOP3;
                  scl_out <= 1'b1;
                  sda_out <= 1'b1;
               end
               K_STOP3: begin
                  state     <= K_IDLE;
                  bus_owned <= 1'b0;
                  cmd_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= '0;
                  rsp_nack  <= 1'b0;
               end
               default: state <= K_IDLE;
            endcase
         end
      end
   end

endmodule
